prio_encoder_pipe: RTL and testbench
====================================

Name: prio_encoder_pipe

Overview:
- Parametrised, registered successor to the team's 8-to-3 one-hot encoder.
- Encodes an N-bit request vector to a binary index. Four selectable modes: LSB-first priority, MSB-first priority, round-robin priority, and strict one-hot with error detection.
- One-stage output register with valid/ready handshake on both sides.
- Sits between request sources (interrupt lines, arbiter requests) and downstream index consumers.

Parameters:
- N, 8, request vector width; must be at least 2.
- IDX_W, $clog2(N), output index width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  block enable; 0 blocks new input acceptance.
- in_vld  input  1  request vector valid.
- in_rdy  output  1  block can accept a vector this cycle.
- in  input  N  request vector; bit i = request i.
- mode  input  2  00 LSB-first, 01 MSB-first, 10 round-robin, 11 strict one-hot.
- out_vld  output  1  result registers hold an unconsumed result.
- out_rdy  input  1  downstream consumes the result.
- y  output  IDX_W  encoded index.
- v  output  1  at least one request bit was set.
- err  output  1  strict mode only: vector was not exactly one-hot.

Behaviour:
- Reset (asynchronous, active-high): out_vld=0, y=0, v=0, err=0, round-robin pointer ptr=0. Takes effect immediately, including mid-transfer; a pending result is discarded.
- in_rdy = en & (~out_vld | out_rdy). This is combinational and gives full throughput of 1 vector/cycle.
- Accept occurs when in_vld & in_rdy. Result registers load on the next rising edge: latency 1 cycle.
- If there is no accept and out_rdy & out_vld, then out_vld clears next edge. Otherwise out_vld, y, v and err hold.
- mode is sampled only on the accept cycle. Changing mode has no effect on a held result.
- v = |in for all modes.
- in == 0 in any mode: y=0, v=0. err=1 in mode 11, err=0 otherwise. ptr unchanged.
- Mode 00: y = index of the lowest set bit; err=0.
- Mode 01: y = index of the highest set bit; err=0.
- Mode 10:
  - y = first set bit at or above ptr, scanning upward and wrapping from N-1 to 0; err=0.
  - On accept with v=1, ptr <= (y+1) mod N. When y=N-1, ptr wraps to 0.
  - ptr is not updated in other modes.
- Mode 11:
  - Exactly one bit set: y = that index, err=0.
  - Zero or more than one bit set: err=1, y=0.
- en=0 forces in_rdy=0 only. A held result still drains normally via out_rdy.
- Non-power-of-2 N: ptr stays within 0..N-1. The wrap compares against N-1, not 2^IDX_W-1.
- Simultaneous accept and drain (out_vld=1, out_rdy=1, in_vld=1, en=1): the new result replaces the old on the same edge and out_vld stays 1.
- y/v/err are stable while out_vld=1 and out_rdy=0.
- Outputs are never X or Z. Unused or zero-request cases drive 0.

Decomposition:
- Shared package prio_enc_pkg holds the mode typedef (enum of 2 bits: MODE_LSB=0, MODE_MSB=1, MODE_RR=2, MODE_ONEHOT=3).
- Sub-module prio_lsb_find: combinational, parametrised by N; returns the lowest set index plus a found flag.
  - MSB mode reuses it on the bit-reversed vector.
  - RR mode uses it twice: on in & mask(ptr..N-1), falling back to the full vector when the masked search finds nothing.
- Top level holds the handshake, result registers and ptr.

Test Plan:
- Reset/idle: assert rst mid-stream with out_vld=1 -> out_vld=0, y=0, v=0, err=0 asynchronously; after release, in_rdy=1 with en=1.
- Priority modes, N=8, in=8'b0010_0100: mode 00 -> y=2, v=1; mode 01 -> y=5, v=1; both with err=0 and result one cycle after accept.
- Round-robin, N=8, in=8'b1000_0101 held for 4 beats -> y=0,2,7,0; ptr after each beat = 1,3,0,1.
- Strict one-hot: in=8'b0001_0000 -> y=4, err=0; in=8'b0001_0001 -> y=0, err=1; in=0 -> v=0, err=1.
- Backpressure: out_rdy=0 for 3 cycles with in_vld=1 -> in_rdy=0, y held. Then out_rdy=1 and in_vld=1 in the same cycle -> new result next edge, out_vld stays 1, no beat lost or duplicated.
- N=5 round-robin: in=5'b10001, ptr reaching 4 -> y=4, then ptr wraps to 0 and next y=0. Also en=0 -> in_rdy=0 while a pending result still drains.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types for the pipelined priority encoder.
package prio_enc_pkg;

  typedef enum logic [1:0] {
    MODE_LSB    = 2'd0,
    MODE_MSB    = 2'd1,
    MODE_RR     = 2'd2,
    MODE_ONEHOT = 2'd3
  } mode_e;

endpackage

// File: rtl/prio_encoder_pipe_if.sv
// Request/result handshake bundle for prio_encoder_pipe.
interface prio_encoder_pipe_if #(
  parameter int unsigned N = 8
) ();
  localparam int unsigned IDX_W = $clog2(N);

  logic             en;
  logic             in_vld;
  logic             in_rdy;
  logic [N-1:0]     in;
  logic [1:0]       mode;
  logic             out_vld;
  logic             out_rdy;
  logic [IDX_W-1:0] y;
  logic             v;
  logic             err;

  modport master (
    output en, in_vld, in, mode, out_rdy,
    input  in_rdy, out_vld, y, v, err
  );

  modport slave (
    input  en, in_vld, in, mode, out_rdy,
    output in_rdy, out_vld, y, v, err
  );
endinterface

// File: rtl/prio_lsb_find.sv
// Combinational lowest-set-bit finder with found flag.
module prio_lsb_find #(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Registered N-bit priority encoder: LSB, MSB, round-robin and strict one-hot modes.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  prio_encoder_pipe_if.slave bus
);

  logic [N-1:0]     req, req_rev, rr_mask;
  logic [IDX_W-1:0] lsb_idx, rev_idx, msk_idx, msb_idx, rr_idx;
  logic             lsb_found, rev_found, msk_found, any, onehot;
  mode_e            mode;

  logic [IDX_W-1:0] ptr_q, ptr_d, y_q, y_d;
  logic             out_vld_q, out_vld_d, v_q, err_q, err_d;
  logic             accept;

  assign req  = bus.in;
  assign mode = mode_e'(bus.mode);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_rev[i] = req[N-1-i];
      rr_mask[i] = (i >= int'(ptr_q));
    end
  end

  prio_lsb_find #(.N(N)) u_lsb (.req(req),           .idx(lsb_idx), .found(lsb_found));
  prio_lsb_find #(.N(N)) u_msb (.req(req_rev),       .idx(rev_idx), .found(rev_found));
  prio_lsb_find #(.N(N)) u_rr  (.req(req & rr_mask), .idx(msk_idx), .found(msk_found));

  assign any     = lsb_found;
  assign msb_idx = IDX_W'(N - 1) - rev_idx;
  // Nothing at or above ptr: wrap to the lowest set bit overall.
  assign rr_idx  = msk_found ? msk_idx : lsb_idx;
  assign onehot  = any && ((req & (req - 1'b1)) == '0);

  assign bus.in_rdy = bus.en & (~out_vld_q | bus.out_rdy);
  assign accept     = bus.in_vld & bus.in_rdy;

  always_comb begin
    y_d   = '0;
    err_d = 1'b0;
    unique case (mode)
      MODE_LSB: y_d = lsb_idx;
      MODE_MSB: if (rev_found) y_d = msb_idx;
      MODE_RR:  y_d = rr_idx;
      MODE_ONEHOT: begin
        if (onehot) y_d = lsb_idx;
        else        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && mode == MODE_RR && any) begin
      ptr_d = (rr_idx == IDX_W'(N - 1)) ? '0 : rr_idx + 1'b1;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    if (accept)                      out_vld_d = 1'b1;
    else if (out_vld_q && bus.out_rdy) out_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      out_vld_q <= 1'b0;
      y_q       <= '0;
      v_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      out_vld_q <= out_vld_d;
      if (accept) begin
        y_q   <= y_d;
        v_q   <= any;
        err_q <= err_d;
      end
    end
  end

  assign bus.out_vld = out_vld_q;
  assign bus.y       = y_q;
  assign bus.v       = v_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench for prio_encoder_pipe at N=8 and N=5.
module tb_prio_encoder_pipe;

  typedef struct {
    int y;
    bit v;
    bit err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  prio_encoder_pipe_if #(.N(8)) b8 ();
  prio_encoder_pipe_if #(.N(5)) b5 ();

  prio_encoder_pipe #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
  prio_encoder_pipe #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q8[$];
  exp_t q5[$];
  int   ptr8 = 0, ptr5 = 0;
  bit   acc8 = 0, acc5 = 0, lat8 = 0, lat5 = 0, hold8 = 0, hold5 = 0;
  int   hy8, hy5;
  bit   hv8, hv5, he8, he5;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: direct reading of the encoding rules on the first n bits.
  function automatic exp_t model(input logic [7:0] vec, input int n, input logic [1:0] m,
                                 inout int ptr);
    exp_t e;
    int   ones;
    e    = '{0, 0, 0};
    ones = 0;
    for (int i = 0; i < n; i++) if (vec[i]) ones++;
    e.v = (ones > 0);
    if (ones == 0) begin
      e.err = (m == 2'd3);
      return e;
    end
    case (m)
      2'd0: for (int i = n - 1; i >= 0; i--) if (vec[i]) e.y = i;
      2'd1: for (int i = 0; i < n; i++) if (vec[i]) e.y = i;
      2'd2: begin
        for (int k = n - 1; k >= 0; k--) if (vec[(ptr + k) % n]) e.y = (ptr + k) % n;
        ptr = (e.y + 1) % n;
      end
      default: begin
        if (ones == 1) for (int i = 0; i < n; i++) begin if (vec[i]) e.y = i; end
        else e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  // One clock of stimulus; the unselected DUT idles with out_rdy=1.
  task automatic cycle(input int sel, input bit vld, input logic [7:0] vec, input logic [1:0] m,
                       input bit e, input bit ordy, output bit acc);
    exp_t x;
    @(negedge clk);
    lat8 = acc8; lat5 = acc5; acc8 = 0; acc5 = 0;
    b8.in_vld = (sel == 0) ? vld : 1'b0;  b8.in = vec;
    b8.mode = m;  b8.en = (sel == 0) ? e : 1'b1;  b8.out_rdy = (sel == 0) ? ordy : 1'b1;
    b5.in_vld = (sel == 1) ? vld : 1'b0;  b5.in = vec[4:0];
    b5.mode = m;  b5.en = (sel == 1) ? e : 1'b1;  b5.out_rdy = (sel == 1) ? ordy : 1'b1;
    #1;
    acc = 0;
    if (sel == 0 && b8.in_vld && b8.in_rdy) begin
      acc = 1; acc8 = 1; x = model(vec, 8, m, ptr8); q8.push_back(x);
    end
    if (sel == 1 && b5.in_vld && b5.in_rdy) begin
      acc = 1; acc5 = 1; x = model(vec, 5, m, ptr5); q5.push_back(x);
    end
  endtask

  task automatic send(input int sel, input logic [7:0] vec, input logic [1:0] m);
    bit acc;
    acc = 0;
    for (int k = 0; k < 20 && !acc; k++) cycle(sel, 1, vec, m, 1, 1, acc);
    chk(acc, "send_timeout", int'(acc), 1);
  endtask

  task automatic idle(input int cycles);
    bit acc;
    for (int k = 0; k < cycles; k++) cycle(0, 0, 8'h00, 2'd0, 1, 1, acc);
  endtask

  always begin
    exp_t x;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (lat8) chk(b8.out_vld == 1'b1, "latency8", int'(b8.out_vld), 1);
      if (hold8) chk(b8.out_vld && int'(b8.y) == hy8 && b8.v == hv8 && b8.err == he8,
                     "hold8_y", int'(b8.y), hy8);
      if (b8.out_vld && b8.out_rdy) begin
        if (q8.size() == 0) chk(1'b0, "unexpected8", int'(b8.y), -1);
        else begin
          x = q8.pop_front();
          n_checks++;
          if (int'(b8.y) != x.y || b8.v != x.v || b8.err != x.err) begin
            n_errors++;
            $display("FAIL score8: got y=%0d v=%0d err=%0d, expected y=%0d v=%0d err=%0d",
                     b8.y, b8.v, b8.err, x.y, x.v, x.err);
          end
        end
      end
      hold8 = b8.out_vld && !b8.out_rdy; hy8 = int'(b8.y); hv8 = b8.v; he8 = b8.err;
    end
  end

  always begin
    exp_t x;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (lat5) chk(b5.out_vld == 1'b1, "latency5", int'(b5.out_vld), 1);
      if (hold5) chk(b5.out_vld && int'(b5.y) == hy5 && b5.v == hv5 && b5.err == he5,
                     "hold5_y", int'(b5.y), hy5);
      if (b5.out_vld && b5.out_rdy) begin
        if (q5.size() == 0) chk(1'b0, "unexpected5", int'(b5.y), -1);
        else begin
          x = q5.pop_front();
          n_checks++;
          if (int'(b5.y) != x.y || b5.v != x.v || b5.err != x.err) begin
            n_errors++;
            $display("FAIL score5: got y=%0d v=%0d err=%0d, expected y=%0d v=%0d err=%0d",
                     b5.y, b5.v, b5.err, x.y, x.v, x.err);
          end
        end
      end
      hold5 = b5.out_vld && !b5.out_rdy; hy5 = int'(b5.y); hv5 = b5.v; he5 = b5.err;
    end
  end

  initial begin
    bit         acc;
    logic [7:0] vec;
    logic [1:0] m;
    int         r;
    rst = 1'b1;
    b8.en = 1; b8.in_vld = 0; b8.in = '0; b8.mode = '0; b8.out_rdy = 1;
    b5.en = 1; b5.in_vld = 0; b5.in = '0; b5.mode = '0; b5.out_rdy = 1;
    #12;
    chk(b8.out_vld == 0 && b8.y == 0 && b8.v == 0 && b8.err == 0, "reset_out", int'(b8.out_vld), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk(b8.in_rdy == 1'b1, "rdy_after_reset", int'(b8.in_rdy), 1);

    send(0, 8'b0010_0100, 2'd0);
    send(0, 8'b0010_0100, 2'd1);
    for (int k = 0; k < 4; k++) send(0, 8'b1000_0101, 2'd2);
    send(0, 8'b0001_0000, 2'd3);
    send(0, 8'b0001_0001, 2'd3);
    send(0, 8'b0000_0000, 2'd3);
    idle(2);

    // Backpressure, then simultaneous drain and accept.
    cycle(0, 1, 8'h12, 2'd0, 1, 0, acc);
    chk(acc, "bp_first", int'(acc), 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 8'h60, 2'd1, 1, 0, acc);
      chk(!acc && !b8.in_rdy, "bp_stall", int'(b8.in_rdy), 0);
    end
    cycle(0, 1, 8'h60, 2'd1, 1, 1, acc);
    chk(acc, "bp_swap", int'(acc), 1);
    idle(2);

    // Asynchronous reset with a held result.
    cycle(0, 1, 8'h81, 2'd2, 1, 0, acc);
    cycle(0, 0, 8'h00, 2'd0, 1, 0, acc);
    chk(b8.out_vld == 1'b1, "pre_reset_vld", int'(b8.out_vld), 1);
    #2 rst = 1'b1;
    #1;
    chk(b8.out_vld == 0 && b8.y == 0 && b8.v == 0 && b8.err == 0, "async_reset",
        int'(b8.out_vld), 0);
    q8.delete(); q5.delete();
    ptr8 = 0; ptr5 = 0;
    acc8 = 0; acc5 = 0; lat8 = 0; lat5 = 0; hold8 = 0; hold5 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk(b8.in_rdy == 1'b1, "rdy_after_rst2", int'(b8.in_rdy), 1);

    // N=5 round-robin wrap: expected y = 0,4,0,4.
    for (int k = 0; k < 4; k++) send(1, 8'b0001_0001, 2'd2);
    idle(2);

    // en=0 blocks new input but the held result drains.
    cycle(1, 1, 8'h03, 2'd0, 1, 0, acc);
    cycle(1, 1, 8'h04, 2'd0, 0, 1, acc);
    chk(!acc && !b5.in_rdy, "en_block", int'(b5.in_rdy), 0);
    cycle(1, 0, 8'h00, 2'd0, 1, 1, acc);
    chk(b5.out_vld == 1'b0, "en_drain", int'(b5.out_vld), 0);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 400; k++) begin
        r = $urandom_range(0, 3);
        case (r)
          0:       vec = 8'h00;
          1:       vec = 8'h01 << $urandom_range(0, (s == 0) ? 7 : 4);
          default: vec = 8'($urandom);
        endcase
        m = 2'($urandom_range(0, 3));
        cycle(s, $urandom_range(0, 3) != 0, vec, m, $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) < 7, acc);
      end
      idle(3);
    end

    chk(q8.size() == 0, "drain8", q8.size(), 0);
    chk(q5.size() == 0, "drain5", q5.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
